accel_operand_issuer: RTL and testbench
=======================================

Name: accel_operand_issuer

Overview:
Initiator end of the stb/ack operand/result protocol used by the execution-unit accelerators. It accepts a two-operand command from the core-side valid/ready port and drives operand A, then operand B, to the accelerator with stb/ack handshakes. It then acks the accelerator's result and returns it on a valid/ready response port. A watchdog aborts transactions that stall.

Parameters:
TIMEOUT_CYCLES, 1024, cycles allowed per transaction before abort; 0 disables the watchdog.
TO_W, 16, width of the watchdog counter; TIMEOUT_CYCLES must be less than 2^TO_W.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  issuer can accept a command
cmd_a  in  32  operand A
cmd_b  in  32  operand B
rsp_valid  out  1  response present
rsp_ready  in  1  core accepts the response
rsp_data  out  32  result, or 0 on timeout
rsp_timeout  out  1  response was produced by a watchdog abort
output_a  out  32  operand A to the accelerator
output_a_stb  out  1  operand A strobe
output_a_ack  in  1  accelerator ready for A
output_b  out  32  operand B to the accelerator
output_b_stb  out  1  operand B strobe
output_b_ack  in  1  accelerator ready for B
input_z  in  32  result from the accelerator
input_z_stb  in  1  result strobe
input_z_ack  out  1  issuer ready for the result
busy  out  1  state is not IDLE

Behaviour:
- One clock, clk. rst is asynchronous and active-high, and forces the state to IDLE from any state, including mid-handshake.
- Reset values: all stb/ack outputs 0, rsp_valid 0, rsp_timeout 0, rsp_data 0, output_a 0, output_b 0, watchdog 0, cmd_ready 1, busy 0.
- Transfer rule for every stb/ack pair: a transfer occurs on a rising edge where stb and ack are both 1. The side holding stb keeps stb and data stable until that edge, then drops stb in the following cycle. The issuer never drops a stb before the transfer completes.
- cmd_ready = (state == IDLE). busy = !cmd_ready. Both are decoded from the state register only.
- IDLE:
  - On cmd_valid && cmd_ready: register cmd_a into output_a and cmd_b into output_b.
  - Set output_a_stb=1, clear the watchdog, go to SEND_A.
- SEND_A:
  - On output_a_stb && output_a_ack: output_a_stb <= 0, output_b_stb <= 1, go to SEND_B.
- SEND_B:
  - On output_b_stb && output_b_ack: output_b_stb <= 0, input_z_ack <= 1, go to WAIT_Z.
- WAIT_Z:
  - On input_z_stb && input_z_ack: rsp_data <= input_z, input_z_ack <= 0, rsp_valid <= 1, rsp_timeout <= 0, go to RESP.
- RESP:
  - On rsp_valid && rsp_ready: rsp_valid <= 0, go to IDLE.
  - rsp_data and rsp_timeout hold until this handshake.
- Acks arriving early (before the matching stb) are legal and cause no transfer. Strobes on input_z_stb outside WAIT_Z are ignored.
- output_a and output_b are held stable from command accept until the next command accept.
- Latency: with ack/stb already high, the command-accept edge to rsp_valid=1 takes 4 edges (accept, A, B, Z). Each slave wait cycle adds 1.
- Back-to-back: a new command is accepted in the cycle after the response handshake, when state is IDLE. There is no overlap between transactions.
- Watchdog (TIMEOUT_CYCLES>0):
  - Increments each cycle in SEND_A, SEND_B and WAIT_Z. It is not cleared between phases.
  - When it reaches TIMEOUT_CYCLES-1 without the pending handshake completing that edge: all stb/ack outputs <= 0, rsp_data <= 0, rsp_timeout <= 1, rsp_valid <= 1, go to RESP.
  - A handshake that completes on the expiry edge takes priority, and no timeout is raised.
  - After a timeout the accelerator may be mid-transaction. Recovery requires rst.
- The watchdog saturates and never wraps.

Test Plan:
- Reset checks: assert rst asynchronously between clock edges while in SEND_B -> all stb/ack and rsp_valid read 0 immediately; cmd_ready=1 after release.
- Zero-wait slave:
  - Stimulus: cmd a=32'h3F800000, b=32'h40000000; output_a_ack and output_b_ack tied 1; input_z=32'h3F000000 with stb held 1.
  - Required: rsp_valid rises 4 edges after the accept edge; rsp_data=32'h3F000000; rsp_timeout=0.
- Slow slave:
  - Stimulus: output_a_ack 3 cycles late, output_b_ack 2 cycles late, input_z_stb 5 cycles late.
  - Required: stb held stable with constant data throughout; each stb drops exactly 1 cycle after its transfer; latency = 4+10 edges.
- Response backpressure:
  - Stimulus: rsp_ready=0 for 6 cycles.
  - Required: rsp_valid/rsp_data stable; cmd_ready=0 throughout; a second cmd_valid is not accepted until after the rsp handshake.
- Timeout, no result:
  - Stimulus: TIMEOUT_CYCLES=8; input_z_stb never asserted.
  - Required: rsp_valid=1 with rsp_timeout=1 and rsp_data=0, 8 cycles after the accept; input_z_ack=0.
- Timeout boundary:
  - Stimulus: TIMEOUT_CYCLES=8; input_z_stb asserted on the expiry edge.
  - Required: normal response, rsp_timeout=0, rsp_data=input_z.
- Back-to-back commands: issue 3 commands with rsp_ready=1 and a zero-wait slave -> each command is accepted exactly 1 cycle after the previous response handshake; results are returned in order.

Source files
------------

// File: rtl/accel_operand_issuer_if.sv
// Signal bundle between the core-side command/response ports, the issuer and the accelerator operand/result ports.
// The master modport is the issuer; the slave modport is the core plus accelerator side.
interface accel_operand_issuer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_timeout;
  logic [31:0] output_a;
  logic        output_a_stb;
  logic        output_a_ack;
  logic [31:0] output_b;
  logic        output_b_stb;
  logic        output_b_ack;
  logic [31:0] input_z;
  logic        input_z_stb;
  logic        input_z_ack;
  logic        busy;

  modport master (
    input  cmd_valid, cmd_a, cmd_b, rsp_ready,
    input  output_a_ack, output_b_ack, input_z, input_z_stb,
    output cmd_ready, rsp_valid, rsp_data, rsp_timeout,
    output output_a, output_a_stb, output_b, output_b_stb, input_z_ack, busy
  );

  modport slave (
    output cmd_valid, cmd_a, cmd_b, rsp_ready,
    output output_a_ack, output_b_ack, input_z, input_z_stb,
    input  cmd_ready, rsp_valid, rsp_data, rsp_timeout,
    input  output_a, output_a_stb, output_b, output_b_stb, input_z_ack, busy
  );
endinterface

// File: rtl/accel_operand_issuer.sv
// Issues a two-operand command to an accelerator over stb/ack, collects the result and returns it on a
// valid/ready response port; a watchdog turns a stalled transaction into a timeout response.
//
// state  | meaning
// IDLE   | waiting for a command, cmd_ready high
// SEND_A | output_a_stb high, waiting for output_a_ack
// SEND_B | output_b_stb high, waiting for output_b_ack
// WAIT_Z | input_z_ack high, waiting for input_z_stb
// RESP   | rsp_valid high, waiting for rsp_ready
module accel_operand_issuer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned TO_W           = 16
) (
  input logic                    clk,
  input logic                    rst,
  accel_operand_issuer_if.master bus
);

  typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, WAIT_Z, RESP} state_t;

  localparam logic [TO_W-1:0] WD_LAST = (TIMEOUT_CYCLES == 0) ? '0 : TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] WD_SAT  = '1;

  state_t          state;
  logic [TO_W-1:0] wd;
  logic            hs;
  logic            expired;

  always_comb begin
    hs = 1'b0;
    case (state)
      SEND_A:  hs = bus.output_a_stb & bus.output_a_ack;
      SEND_B:  hs = bus.output_b_stb & bus.output_b_ack;
      WAIT_Z:  hs = bus.input_z_stb & bus.input_z_ack;
      default: hs = 1'b0;
    endcase
  end

  // A handshake landing on the expiry edge wins over the abort.
  assign expired = (TIMEOUT_CYCLES != 0) && (wd == WD_LAST) && !hs;

  assign bus.cmd_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      wd               <= '0;
      bus.output_a     <= '0;
      bus.output_b     <= '0;
      bus.output_a_stb <= 1'b0;
      bus.output_b_stb <= 1'b0;
      bus.input_z_ack  <= 1'b0;
      bus.rsp_valid    <= 1'b0;
      bus.rsp_data     <= '0;
      bus.rsp_timeout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            bus.output_a     <= bus.cmd_a;
            bus.output_b     <= bus.cmd_b;
            bus.output_a_stb <= 1'b1;
            wd               <= '0;
            state            <= SEND_A;
          end
        end
        SEND_A, SEND_B, WAIT_Z: begin
          if (wd != WD_SAT) wd <= wd + 1'b1;
          if (expired) begin
            bus.output_a_stb <= 1'b0;
            bus.output_b_stb <= 1'b0;
            bus.input_z_ack  <= 1'b0;
            bus.rsp_data     <= '0;
            bus.rsp_timeout  <= 1'b1;
            bus.rsp_valid    <= 1'b1;
            state            <= RESP;
          end else if (hs) begin
            case (state)
              SEND_A: begin
                bus.output_a_stb <= 1'b0;
                bus.output_b_stb <= 1'b1;
                state            <= SEND_B;
              end
              SEND_B: begin
                bus.output_b_stb <= 1'b0;
                bus.input_z_ack  <= 1'b1;
                state            <= WAIT_Z;
              end
              default: begin
                bus.rsp_data    <= bus.input_z;
                bus.input_z_ack <= 1'b0;
                bus.rsp_valid   <= 1'b1;
                bus.rsp_timeout <= 1'b0;
                state           <= RESP;
              end
            endcase
          end
        end
        RESP: begin
          if (bus.rsp_valid && bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_accel_operand_issuer.sv
// Self-checking bench: a delay-programmable accelerator model, a response scoreboard, a vector table
// and hand-written reset and back-to-back sequences. dut uses the default watchdog, dut8 uses 8 cycles.
module tb_accel_operand_issuer;

  logic clk, rst;
  logic        cmd_valid, rsp_ready, a_ack, b_ack, z_stb;
  logic [31:0] cmd_a, cmd_b, z;
  logic        sel;

  accel_operand_issuer_if bus0();
  accel_operand_issuer_if bus8();

  accel_operand_issuer #(.TIMEOUT_CYCLES(1024), .TO_W(16)) dut  (.clk(clk), .rst(rst), .bus(bus0.master));
  accel_operand_issuer #(.TIMEOUT_CYCLES(8),    .TO_W(4))  dut8 (.clk(clk), .rst(rst), .bus(bus8.master));

  assign bus0.cmd_valid = cmd_valid;    assign bus8.cmd_valid = cmd_valid;
  assign bus0.cmd_a = cmd_a;            assign bus8.cmd_a = cmd_a;
  assign bus0.cmd_b = cmd_b;            assign bus8.cmd_b = cmd_b;
  assign bus0.rsp_ready = rsp_ready;    assign bus8.rsp_ready = rsp_ready;
  assign bus0.output_a_ack = a_ack;     assign bus8.output_a_ack = a_ack;
  assign bus0.output_b_ack = b_ack;     assign bus8.output_b_ack = b_ack;
  assign bus0.input_z = z;              assign bus8.input_z = z;
  assign bus0.input_z_stb = z_stb;      assign bus8.input_z_stb = z_stb;

  logic        o_cmd_ready, o_rsp_valid, o_rsp_timeout, o_a_stb, o_b_stb, o_z_ack, o_busy;
  logic [31:0] o_rsp_data, o_a, o_b;

  always_comb begin
    o_cmd_ready   = sel ? bus8.cmd_ready    : bus0.cmd_ready;
    o_rsp_valid   = sel ? bus8.rsp_valid    : bus0.rsp_valid;
    o_rsp_data    = sel ? bus8.rsp_data     : bus0.rsp_data;
    o_rsp_timeout = sel ? bus8.rsp_timeout  : bus0.rsp_timeout;
    o_a           = sel ? bus8.output_a     : bus0.output_a;
    o_a_stb       = sel ? bus8.output_a_stb : bus0.output_a_stb;
    o_b           = sel ? bus8.output_b     : bus0.output_b;
    o_b_stb       = sel ? bus8.output_b_stb : bus0.output_b_stb;
    o_z_ack       = sel ? bus8.input_z_ack  : bus0.input_z_ack;
    o_busy        = sel ? bus8.busy         : bus0.busy;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        to;
  } exp_t;

  typedef struct {
    logic        sel;
    logic [31:0] a, b, z;
    int          da, db, dz, bp, lat;
    logic        to;
  } vec_t;

  exp_t sbq[$];
  exp_t pend;
  vec_t vecs[9];

  int n_cmp = 0, n_bad = 0;
  int edges = 0, acc_edge = -1, rv_edge = -1, hs_edge = -1;
  int da = 0, db = 0, dz = 0, cnt_a = 0, cnt_b = 0, cnt_z = 0;
  logic        z_sum = 1'b0;
  logic [31:0] z_fixed = '0;
  logic        pa_stb, pa_ack, pb_stb, pb_ack, pz_ack, pz_stb, prv, prdy;
  logic [31:0] pa_dat, pb_dat, prd;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Accelerator model: each ack/stb rises a programmed number of cycles after the issuer's strobe/ack.
  task automatic slave_step();
    cnt_a = o_a_stb ? cnt_a + 1 : 0;
    cnt_b = o_b_stb ? cnt_b + 1 : 0;
    cnt_z = o_z_ack ? cnt_z + 1 : 0;
    a_ack = (cnt_a > da);
    b_ack = (cnt_b > db);
    z_stb = (cnt_z > dz);
    z     = z_sum ? o_a + o_b : z_fixed;
  endtask

  // Called between a falling and a rising edge with inputs settled; returns at the next falling edge.
  task automatic tick();
    exp_t e;
    if (cmd_valid && o_cmd_ready) begin
      sbq.push_back(pend);
      acc_edge = edges + 1;
    end
    if (o_rsp_valid && rsp_ready) begin
      hs_edge = edges + 1;
      if (sbq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_rsp: got data %h with nothing expected", o_rsp_data);
      end else begin
        e = sbq.pop_front();
        check32("rsp_data", o_rsp_data, e.data);
        check1("rsp_timeout", o_rsp_timeout, e.to);
      end
    end
    pa_stb = o_a_stb; pa_ack = a_ack; pa_dat = o_a;
    pb_stb = o_b_stb; pb_ack = b_ack; pb_dat = o_b;
    pz_ack = o_z_ack; pz_stb = z_stb;
    prv = o_rsp_valid; prdy = rsp_ready; prd = o_rsp_data;
    @(posedge clk);
    edges++;
    @(negedge clk);
    if (!(o_rsp_valid && o_rsp_timeout)) begin
      if (pa_stb && pa_ack) check1("a_stb_drop", o_a_stb, 1'b0);
      if (pa_stb && !pa_ack) begin
        check1("a_stb_hold", o_a_stb, 1'b1);
        check32("a_data_hold", o_a, pa_dat);
      end
      if (pb_stb && pb_ack) check1("b_stb_drop", o_b_stb, 1'b0);
      if (pb_stb && !pb_ack) begin
        check1("b_stb_hold", o_b_stb, 1'b1);
        check32("b_data_hold", o_b, pb_dat);
      end
      if (pz_ack && pz_stb) check1("z_ack_drop", o_z_ack, 1'b0);
    end
    if (prv && !prdy) begin
      check1("rsp_valid_hold", o_rsp_valid, 1'b1);
      check32("rsp_data_hold", o_rsp_data, prd);
    end
    if (o_rsp_valid && !prv) rv_edge = edges;
    slave_step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    cmd_valid = 1'b0; a_ack = 1'b0; b_ack = 1'b0; z_stb = 1'b0;
    cnt_a = 0; cnt_b = 0; cnt_z = 0;
    sbq.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    int k;
    v = vecs[idx];
    if (v.sel != sel) begin
      sel = v.sel;
      do_reset();
    end
    da = v.da; db = v.db; dz = v.dz; z_sum = 1'b0; z_fixed = v.z;
    pend.data = v.to ? 32'h0 : v.z;
    pend.to   = v.to;
    cmd_a = v.a; cmd_b = v.b; cmd_valid = 1'b1;
    rsp_ready = (v.bp == 0);
    acc_edge = -1; rv_edge = -1;
    k = 0;
    while (acc_edge < 0 && k < 50) begin tick(); k++; end
    cmd_valid = 1'b0;
    check1("accept_seen", acc_edge >= 0, 1'b1);
    check32("output_a_latched", o_a, v.a);
    check32("output_b_latched", o_b, v.b);
    k = 0;
    while (rv_edge < 0 && k < 200) begin tick(); k++; end
    // edges counted including the accept edge
    check32("latency", 32'(rv_edge - acc_edge + 1), 32'(v.lat));
    if (v.to) begin
      check1("to_a_stb", o_a_stb, 1'b0);
      check1("to_b_stb", o_b_stb, 1'b0);
      check1("to_z_ack", o_z_ack, 1'b0);
    end
    for (int i = 0; i < v.bp; i++) begin
      cmd_valid = 1'b1;
      cmd_a = ~v.a;
      check1("bp_cmd_ready", o_cmd_ready, 1'b0);
      check1("bp_busy", o_busy, 1'b1);
      tick();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    k = 0;
    while (sbq.size() > 0 && k < 50) begin tick(); k++; end
    check1("rsp_drained", sbq.size() == 0, 1'b1);
    sbq.delete();
    check1("idle_after_rsp", o_cmd_ready, 1'b1);
  endtask

  logic [31:0] b2b_a[3], b2b_b[3];

  initial begin
    int k;
    vecs[0] = '{1'b0, 32'h3F800000, 32'h40000000, 32'h3F000000, 0, 0, 0, 0, 4, 1'b0};
    vecs[1] = '{1'b0, 32'hC0490FDB, 32'h402DF854, 32'h12345678, 3, 2, 5, 0, 14, 1'b0};
    vecs[2] = '{1'b0, 32'h00000001, 32'h00000002, 32'hDEADBEEF, 0, 0, 0, 6, 4, 1'b0};
    vecs[3] = '{1'b0, 32'hAAAA5555, 32'h5555AAAA, 32'h0F0F0F0F, 1, 0, 2, 0, 7, 1'b0};
    vecs[4] = '{1'b1, 32'h11112222, 32'h33334444, 32'hCAFEF00D, 0, 0, 1000, 0, 9, 1'b1};
    vecs[5] = '{1'b1, 32'h55556666, 32'h77778888, 32'h600DF00D, 0, 0, 5, 0, 9, 1'b0};
    vecs[6] = '{1'b1, 32'h9999AAAA, 32'hBBBBCCCC, 32'hBAADF00D, 0, 0, 6, 0, 9, 1'b1};
    vecs[7] = '{1'b1, 32'hDDDDEEEE, 32'hFFFF0000, 32'h01234567, 1000, 0, 0, 2, 9, 1'b1};
    vecs[8] = '{1'b0, 32'h80000000, 32'h7FFFFFFF, 32'hFEDCBA98, 0, 4, 0, 2, 8, 1'b0};

    sel = 1'b0; rst = 1'b1;
    cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b0;
    a_ack = 1'b0; b_ack = 1'b0; z_stb = 1'b0; z = '0;
    pend = '{32'h0, 1'b0};
    repeat (3) @(negedge clk);
    check1("rst_cmd_ready", o_cmd_ready, 1'b1);
    check1("rst_busy", o_busy, 1'b0);
    check1("rst_a_stb", o_a_stb, 1'b0);
    check1("rst_b_stb", o_b_stb, 1'b0);
    check1("rst_z_ack", o_z_ack, 1'b0);
    check1("rst_rsp_valid", o_rsp_valid, 1'b0);
    check1("rst_rsp_timeout", o_rsp_timeout, 1'b0);
    check32("rst_rsp_data", o_rsp_data, 32'h0);
    check32("rst_output_a", o_a, 32'h0);
    check32("rst_output_b", o_b, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_vec(i);

    // back-to-back commands with a zero-wait accelerator that returns a+b
    sel = 1'b0;
    do_reset();
    b2b_a = '{32'h00000010, 32'hFFFFFFFF, 32'h12340000};
    b2b_b = '{32'h00000020, 32'h00000002, 32'h00005678};
    da = 0; db = 0; dz = 0; z_sum = 1'b1; rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pend.data = b2b_a[i] + b2b_b[i];
      pend.to   = 1'b0;
      cmd_a = b2b_a[i]; cmd_b = b2b_b[i]; cmd_valid = 1'b1;
      acc_edge = -1;
      k = 0;
      while (acc_edge < 0 && k < 50) begin tick(); k++; end
      check1("b2b_accept_seen", acc_edge >= 0, 1'b1);
      if (i > 0) check32("b2b_accept_gap", 32'(acc_edge), 32'(hs_edge + 1));
    end
    cmd_valid = 1'b0;
    k = 0;
    while (sbq.size() > 0 && k < 50) begin tick(); k++; end
    check1("b2b_drained", sbq.size() == 0, 1'b1);

    // asynchronous reset while SEND_B is waiting on an ack
    do_reset();
    da = 0; db = 1000; dz = 0; z_sum = 1'b0; z_fixed = 32'hA5A5A5A5;
    pend = '{32'hA5A5A5A5, 1'b0};
    cmd_a = 32'h0BADCAFE; cmd_b = 32'h0DDBA11E; cmd_valid = 1'b1;
    acc_edge = -1;
    k = 0;
    while (acc_edge < 0 && k < 50) begin tick(); k++; end
    cmd_valid = 1'b0;
    k = 0;
    while (!o_b_stb && k < 50) begin tick(); k++; end
    check1("mid_b_stb_seen", o_b_stb, 1'b1);
    #2 rst = 1'b1;
    #1;
    check1("async_b_stb", o_b_stb, 1'b0);
    check1("async_a_stb", o_a_stb, 1'b0);
    check1("async_z_ack", o_z_ack, 1'b0);
    check1("async_rsp_valid", o_rsp_valid, 1'b0);
    check32("async_output_b", o_b, 32'h0);
    #1 rst = 1'b0;
    sbq.delete();
    db = 0; a_ack = 1'b0; b_ack = 1'b0; cnt_a = 0; cnt_b = 0; cnt_z = 0;
    @(negedge clk);
    check1("post_rst_cmd_ready", o_cmd_ready, 1'b1);
    check1("post_rst_busy", o_busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation still running at %0t", $time);
    $fatal(1, "time limit");
  end

endmodule
